// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boots for one cycle, then steps, branches or jumps
// each unstalled cycle until it halts or faults on a misaligned target.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [15:0] L,
   input  logic        jr_taken,
   input  logic [31:0] jr_target,
   input  logic        halt,
   output logic [31:0] PC,
   output logic [31:0] link,
   output logic        fetch_valid,
   output logic        halted,
   output logic        fault,
   output logic [31:0] icount
);

   typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

   state_t      state;
   logic [31:0] next_pc;
   logic [31:0] branch_pc;
   logic [31:0] seq_pc;

   assign seq_pc    = PC + 32'd4;
   assign branch_pc = PC + {{16{L[15]}}, L};
   assign link      = seq_pc;

   // Redirect priority below halt; halt itself is resolved in the state machine.
   always_comb begin
      next_pc = seq_pc;
      if (jr_taken)
         next_pc = jr_target;
      else if (br_taken)
         next_pc = branch_pc;
   end

   // Status flags are registered alongside the state so they never see inputs
   // combinationally; a misaligned target parks the PC at the issuing address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= BOOT;
         PC          <= RESET_PC;
         icount      <= 32'd0;
         fetch_valid <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state       <= RUN;
               fetch_valid <= 1'b1;
            end
            RUN: begin
               if (!stall) begin
                  if (halt) begin
                     state       <= HALT;
                     fetch_valid <= 1'b0;
                     halted      <= 1'b1;
                  end else if (next_pc[1:0] != 2'b00) begin
                     state       <= FAULT;
                     fetch_valid <= 1'b0;
                     fault       <= 1'b1;
                  end else begin
                     PC     <= next_pc;
                     icount <= icount + 32'd1;
                  end
               end
            end
            HALT:    state <= HALT;
            FAULT:   state <= FAULT;
            default: state <= FAULT;
         endcase
      end
   end

endmodule
